// File: rtl/rrarb_wrr_hold.sv
// Weighted round-robin N-to-1 arbiter with registered one-hot grant.
// The owner keeps the grant for eff_weight completed transfers, until it
// drops its request, or until it is released. Handover to the next
// requester in circular order happens without an idle cycle.
`timescale 1ns/1ps
module rrarb_wrr_hold #(
   parameter  int REQ_CNT = 4,
   parameter  int WGT_W   = 4,
   localparam int IDX_W   = $clog2(REQ_CNT)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [REQ_CNT-1:0]       req_i,
   input  logic [REQ_CNT*WGT_W-1:0] weight_i,
   input  logic                     done_i,
   input  logic                     release_i,
   output logic [REQ_CNT-1:0]       grant_o,
   output logic                     grant_vld_o,
   output logic [IDX_W-1:0]         grant_idx_o,
   output logic [WGT_W-1:0]         credit_o
);

   // Handshake: req_i is a level held by each requester for as long as it
   // wants the resource. done_i and release_i are single-cycle pulses that
   // refer to the current owner only and are ignored while no grant is
   // held. A transfer counts as completed in the cycle done_i is high.

   // Ownership state is carried by grant_vld_q alone; the enum gives it a
   // readable name for the next-state logic and for checkers.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_e;

   logic [REQ_CNT-1:0] grant_q,     grant_d;
   logic               grant_vld_q, grant_vld_d;
   logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
   logic [WGT_W-1:0]   credit_q,    credit_d;
   logic [IDX_W-1:0]   ptr_q,       ptr_d;

   state_e           state;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic [WGT_W-1:0] win_credit;
   logic             switch_ev;

   assign state = state_e'(grant_vld_q);

   // Index that lies 'step' positions after 'base' in circular order.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                 input int               step);
      int sum;
      sum = int'(base) + step;
      return IDX_W'(sum % REQ_CNT);
   endfunction

   // Weight of one requester with zero promoted to one transfer.
   function automatic logic [WGT_W-1:0] eff_weight(input logic [REQ_CNT*WGT_W-1:0] wv,
                                                   input logic [IDX_W-1:0]         idx);
      logic [WGT_W-1:0] w;
      w = wv[idx*WGT_W +: WGT_W];
      return (w == '0) ? WGT_W'(1) : w;
   endfunction

   // Circular search starting after the last owner; the last owner itself
   // is examined last, so it is regranted only when nobody else asks.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 1; k <= REQ_CNT; k++) begin
         cand = wrap_add(ptr_q, k);
         if (!win_found && req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_credit = eff_weight(weight_i, win_idx);

   // Next-state logic: grant, hold with credit countdown, handover or idle.
   always_comb begin
      grant_d     = grant_q;
      grant_vld_d = grant_vld_q;
      grant_idx_d = grant_idx_q;
      credit_d    = credit_q;
      ptr_d       = ptr_q;
      switch_ev   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (win_found) begin
               grant_d     = REQ_CNT'(1) << win_idx;
               grant_vld_d = 1'b1;
               grant_idx_d = win_idx;
               credit_d    = win_credit;
               ptr_d       = win_idx;
            end
         end
         ST_OWN: begin
            // A simultaneous done is absorbed by the switch: credit is
            // reloaded or cleared, never decremented on the same edge.
            switch_ev = (done_i && (credit_q == WGT_W'(1))) || release_i
                        || !req_i[grant_idx_q];
            if (switch_ev) begin
               if (win_found) begin
                  grant_d     = REQ_CNT'(1) << win_idx;
                  grant_vld_d = 1'b1;
                  grant_idx_d = win_idx;
                  credit_d    = win_credit;
                  ptr_d       = win_idx;
               end else begin
                  grant_d     = '0;
                  grant_vld_d = 1'b0;
                  credit_d    = '0;
               end
            end else if (done_i) begin
               credit_d = credit_q - WGT_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // State flops; ptr resets to the top index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q     <= '0;
         grant_vld_q <= 1'b0;
         grant_idx_q <= '0;
         credit_q    <= '0;
         ptr_q       <= IDX_W'(REQ_CNT - 1);
      end else begin
         grant_q     <= grant_d;
         grant_vld_q <= grant_vld_d;
         grant_idx_q <= grant_idx_d;
         credit_q    <= credit_d;
         ptr_q       <= ptr_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_vld_o = grant_vld_q;
   assign grant_idx_o = grant_idx_q;
   assign credit_o    = credit_q;

endmodule

// File: tb/tb_rrarb_wrr_hold.sv
// Bench for rrarb_wrr_hold: directed scenarios followed by random traffic,
// every cycle compared against an owner/credit model of the arbiter.
`timescale 1ns/1ps
module tb_rrarb_wrr_hold;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int IW = 2;

   // Clock and reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]   req_i;
   logic [N*W-1:0] weight_i;
   logic           done_i;
   logic           release_i;
   logic [N-1:0]   grant_o;
   logic           grant_vld_o;
   logic [IW-1:0]  grant_idx_o;
   logic [W-1:0]   credit_o;

   rrarb_wrr_hold #(.REQ_CNT(N), .WGT_W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .weight_i   (weight_i),
      .done_i     (done_i),
      .release_i  (release_i),
      .grant_o    (grant_o),
      .grant_vld_o(grant_vld_o),
      .grant_idx_o(grant_idx_o),
      .credit_o   (credit_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model: owner (-1 when idle), remaining credit, last owner, shown index.
   int m_owner;
   int m_credit;
   int m_ptr;
   int m_last;
   logic [N-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int eff_w(input int i);
      int v;
      v = int'(weight_i[i*W +: W]);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int search_from(input int from);
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (from + k) % N;
         if (req_i[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_credit = 0;
      m_ptr    = N - 1;
      m_last   = 0;
      exp_q.delete();
   endtask

   task automatic grant_to(input int w);
      m_owner  = w;
      m_ptr    = w;
      m_last   = w;
      m_credit = eff_w(w);
   endtask

   task automatic push_exp();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      exp_q.push_back(g);
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   task automatic model_step();
      int w;
      bit sw;
      if (m_owner < 0) begin
         w = search_from(m_ptr);
         if (w >= 0) grant_to(w);
      end else begin
         sw = (done_i && m_credit == 1) || release_i || !req_i[m_owner];
         if (sw) begin
            w = search_from(m_ptr);
            if (w >= 0) grant_to(w);
            else begin
               m_owner  = -1;
               m_credit = 0;
            end
         end else if (done_i) begin
            m_credit--;
         end
      end
      push_exp();
   endtask

   // Scoreboard: pop expected grant, compare all outputs.
   task automatic compare_all();
      logic [N-1:0] eg;
      eg = exp_q.pop_front();
      check_eq("grant",     32'(grant_o),     32'(eg));
      check_eq("grant_vld", 32'(grant_vld_o), 32'(eg != '0));
      check_eq("grant_idx", 32'(grant_idx_o), 32'(m_last));
      check_eq("credit",    32'(credit_o),    32'(m_credit));
      check_eq("onehot",    32'($countones(grant_o) <= 1), 32'(1));
   endtask

   // Driver: apply inputs at negedge, check the result at the next negedge.
   task automatic cycle(input logic [N-1:0] r, input logic d, input logic rl);
      req_i     = r;
      done_i    = d;
      release_i = rl;
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear at once.
   task automatic mid_reset(input logic [N-1:0] r_after);
      #2;
      rst_n = 1'b0;
      model_reset();
      push_exp();
      #1;
      compare_all();
      check_eq("rst_grant_now", 32'(grant_o), 32'(0));
      req_i     = r_after;
      done_i    = 1'b0;
      release_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      req_i     = '0;
      weight_i  = '0;
      done_i    = 1'b0;
      release_i = 1'b0;
      model_reset();
      @(negedge clk);
      push_exp();
      compare_all();
      @(negedge clk);
      rst_n = 1'b1;

      // All requesting, weight 1, done every cycle: 0001,0010,0100,1000,0001
      weight_i = 16'h1111;
      cycle(4'b1111, 1'b1, 1'b0);
      check_eq("t1_first_grant", 32'(grant_o), 32'(4'b0001));
      for (int i = 0; i < 8; i++) cycle(4'b1111, 1'b1, 1'b0);

      // req0 weight 3: 0001 x3 (credit 3,2,1) then 0010 x1
      mid_reset('0);
      weight_i = 16'h1113;
      cycle(4'b0011, 1'b1, 1'b0);
      check_eq("t2_credit3", 32'(credit_o), 32'(3));
      for (int i = 0; i < 11; i++) cycle(4'b0011, 1'b1, 1'b0);

      // Release at credit 3, then owner drops request
      mid_reset('0);
      weight_i = 16'h0204;
      cycle(4'b0101, 1'b0, 1'b0);
      cycle(4'b0101, 1'b1, 1'b0);
      cycle(4'b0101, 1'b0, 1'b1);
      check_eq("t3_after_release", 32'(grant_o), 32'(4'b0100));
      check_eq("t3_fresh_credit", 32'(credit_o), 32'(2));
      cycle(4'b0001, 1'b0, 1'b0);
      check_eq("t3_after_drop", 32'(grant_o), 32'(4'b0001));

      // Single requester with weight 0 keeps the grant continuously
      mid_reset('0);
      weight_i = 16'h0000;
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1000, 1'b1, 1'b0);
         check_eq("t4_vld_held", 32'(grant_vld_o), 32'(1));
      end

      // done+release together: one handover; then pulses while idle
      mid_reset('0);
      weight_i = 16'h0022;
      cycle(4'b0011, 1'b0, 1'b0);
      cycle(4'b0011, 1'b1, 1'b1);
      check_eq("t5_single_switch", 32'(grant_o), 32'(4'b0010));
      cycle(4'b0011, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
      cycle(4'b0000, 1'b1, 1'b1);
      check_eq("t5_idle_ignore", 32'(grant_vld_o), 32'(0));

      // Reset while requester 2 owns with credit 2
      mid_reset('0);
      weight_i = 16'h0200;
      cycle(4'b0100, 1'b0, 1'b0);
      check_eq("t6_owner2", 32'(grant_o), 32'(4'b0100));
      weight_i = 16'h1111;
      mid_reset(4'b1111);
      cycle(4'b1111, 1'b0, 1'b0);
      check_eq("t6_restart_req0", 32'(grant_o), 32'(4'b0001));

      // Random traffic with occasional weight changes and resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) weight_i = N*W'($urandom);
         if ($urandom_range(0, 499) == 0) mid_reset(N'($urandom));
         cycle(($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 1) << $urandom_range(0, N-1))
                                           : N'($urandom),
               1'($urandom_range(0, 1)),
               1'($urandom_range(0, 9) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rrarb_wrr_hold.md
# rrarb_wrr_hold

Weighted round-robin N-to-1 arbiter with registered one-hot grant and grant hold. It is the parametrised successor of the flopped round-robin arbiter in the spcom arbitration library. Each granted requester keeps ownership for a programmable number of completed transfers (its weight), or until it drops its request or is explicitly released. Ownership then hands over to the next requester in circular order without an idle bubble. It sits in front of shared buses and DMA channels where burst fairness per requester is needed.

## Interface
- REQ_CNT, 4, number of requesters (>= 2)
- WGT_W, 4, width of each per-requester weight field
- IDX_W, $clog2(REQ_CNT), width of grant_idx (derived, not overridden)

- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req  input  REQ_CNT  request vector, level, bit i = requester i
- weight  input  REQ_CNT*WGT_W  per-requester weight, field i at [i*WGT_W +: WGT_W]; quasi-static; 0 is treated as 1
- done  input  1  one-cycle pulse, current owner completed one transfer
- release  input  1  one-cycle pulse, force owner to give up grant
- grant  output  REQ_CNT  registered one-hot grant (all-zero when idle)
- grant_vld  output  1  registered, equals |grant
- grant_idx  output  IDX_W  registered binary index of owner; holds last owner when idle
- credit  output  WGT_W  registered remaining transfers of current owner; 0 when idle

## Operation
- States: IDLE (grant==0), OWN (grant one-hot). State is implied by grant_vld; there is no separate state register beyond the grant flops.
- Pointer ptr (IDX_W bits) = index of last owner. Search order is ptr+1, ptr+2, ... with wrap at REQ_CNT-1 -> 0, ending at ptr itself. The first set req bit wins.
- IDLE: if any req, grant the winner next cycle. credit loads eff_weight(winner) = (weight==0) ? 1 : weight. ptr <= winner.
- OWN, switch event = (done and credit==1) or release or owner's req bit low.
- OWN, no switch event: grant held. done decrements credit by 1. done with credit>1 does not switch.
- OWN, switch event: rerun the search from ptr with the owner included last in the order.
  - Another requester set -> it is granted next cycle with fresh credit.
  - Only the owner still requesting (release or credit exhaustion) -> owner regranted with reloaded credit.
  - No req -> IDLE.
- done and release in the same cycle -> exactly one switch; the decrement is discarded.
- done or release in IDLE -> ignored.
- weight is sampled only at grant/regrant. Changes mid-ownership do not affect the current credit.
- req may change at any time. Only the owner's bit affects OWN; the others matter only at switch time.

## Timing
- Reset values: grant=0, grant_vld=0, grant_idx=0, credit=0, ptr=REQ_CNT-1, so requester 0 has first priority after reset.
- Arbitration latency: 1 cycle. req seen in cycle t (IDLE) -> grant in cycle t+1.
- Handover: switch event in cycle t -> new grant in cycle t+1, old grant deasserted in the same edge. No cycle with grant==0 when a successor exists, and never two bits set.
- Owner req drop in cycle t -> grant moves or clears in cycle t+1. The owner therefore sees grant for one cycle after dropping req.
- Reset asserted mid-ownership -> all outputs immediately take reset values (async). Arbitration restarts from requester 0.
- All outputs come directly from flops. No combinational path exists from any input to any output.

## Test plan
- Reset then req=4'b1111, weight all 1, done every cycle -> grant sequence 0001,0010,0100,1000,0001, each lasting 1 cycle, first grant one cycle after req.
- weight={1,1,1,3} (req0 weight 3), req=4'b0011, done every cycle -> grant 0001 for 3 cycles, credit 3,2,1, then 0010 for 1 cycle, repeating.
- req=4'b0101, owner 0 with credit 4; release pulse at credit 3 -> next cycle grant=0100, credit=eff_weight(2). Then drop req2 with no done -> grant=0001 one cycle later.
- Single requester req=4'b1000, weight=0 (treated as 1), done every cycle -> grant stays 1000 continuously, credit reloaded to 1 each cycle, grant_vld never drops.
- done and release together on owner with credit 2 while req=4'b0011 -> a single handover to the other requester, no double switch. done or release while IDLE -> no change.
- Assert rst_n low while grant=0100 with credit 2 -> grant, grant_vld and credit are 0 immediately. After release of reset with req=4'b1111, the first grant is 0001.
